// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : First-word fall-through instruction queue between the fetch
//               and decode stages. Its depth is a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from the registered count, so no input reaches them.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never cleared; stale entries stay unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (w_push && rst && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Self-checking bench for instr_queue (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

    localparam int WIDTH = 40;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       count;

    int n_tests;
    int n_fail;

    instr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 40'hDEADBEEF01; out_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        n_tests++; if (count !== 3'd0)       begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_data !== 40'h0)   begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        n_tests++; if (count !== 3'd0)       begin n_fail++; $display("FAIL reset_release_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] words [4];
        words[0] = 40'hAABBCCDDEE; words[1] = 40'h1122334455;
        words[2] = 40'h0000000001; words[3] = 40'hFFFFFFFFFF;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
        end
        n_tests++; if (count !== 3'd4)    begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        in_data = 40'h123456789A;
        tick();
        n_tests++; if (count !== 3'd4)    begin n_fail++; $display("FAIL full_push_count: got %0d want 4", count); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_data !== words[i] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_%0d: got %h/v%b want %h/v1", i, out_data, out_valid, words[i]);
            end
            tick();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 40'h0) begin n_fail++; $display("FAIL drained_out_data: got %h want 0", out_data); end
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL drained_count: got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 40'hC0DE000000 + 40'(i * 17 + 3);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = w[0]; tick();
        in_data = w[1]; tick();
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_prefill: got %0d want 2", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = w[i + 2];
            n_tests++;
            if (out_data !== w[i]) begin n_fail++; $display("FAIL b2b_head_%0d: got %h want %h", i, out_data, w[i]); end
            tick();
            n_tests++;
            if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d want 2", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 6; i < 8; i++) begin
            n_tests++;
            if (out_data !== w[i]) begin n_fail++; $display("FAIL b2b_tail_%0d: got %h want %h", i, out_data, w[i]); end
            tick();
        end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 40'h0F0F0F0F00 + 40'(i);
            tick();
        end
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_prefill: got %0d want 3", count); end
        flush = 1'b1; in_data = 40'h5555555555; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        in_data = 40'h7777777777;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_data !== 40'h7777777777 || count !== 3'd1) begin
            n_fail++; $display("FAIL flush_after_push: got %h/%0d want 7777777777/1", out_data, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fall_through();
        in_valid = 1'b1; in_data = 40'hAABBCCDDEE; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 40'hAABBCCDDEE) begin
            n_fail++; $display("FAIL fwft: got %h/v%b want aabbccddee/v1", out_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (count !== 3'd0)    begin n_fail++; $display("FAIL underflow_count: got %0d want 0", count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL underflow_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 40'h0102030405; tick();
        in_data = 40'h060708090A; tick();
        rst = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 40'h0) begin
            n_fail++; $display("FAIL mid_reset: got cnt %0d v%b %h want 0 v0 0", count, out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] mdl [$];
        logic [63:0]      rnd;
        logic             exp_push;
        logic             exp_pop;
        for (int c = 0; c < 1000; c++) begin
            rnd       = {$urandom(), $urandom()};
            in_data   = rnd[WIDTH-1:0];
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            exp_push  = in_valid && (mdl.size() != DEPTH);
            exp_pop   = out_ready && (mdl.size() != 0);
            if (mdl.size() != 0) begin
                n_tests++;
                if (out_data !== mdl[0]) begin n_fail++; $display("FAIL rand_head_c%0d: got %h want %h", c, out_data, mdl[0]); end
            end
            tick();
            if (flush) begin
                mdl.delete();
            end else begin
                if (exp_pop)  void'(mdl.pop_front());
                if (exp_push) mdl.push_back(in_data);
            end
            n_tests++;
            if (count !== 3'(mdl.size())) begin n_fail++; $display("FAIL rand_count_c%0d: got %0d want %0d", c, count, mdl.size()); end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_fall_through();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter WIDTH, default 40, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 flush  input  1  synchronous queue clear, active-high.
REQ-006 in_valid  input  1  producer (fetch side) offers in_data this cycle.
REQ-007 in_data  input  WIDTH  instruction word from the producer.
REQ-008 in_ready  output  1  queue can accept a word this cycle.
REQ-009 out_valid  output  1  head entry available to the consumer (decode side).
REQ-010 out_data  output  WIDTH  head entry contents.
REQ-011 out_ready  input  1  consumer accepts head entry this cycle.
REQ-012 count  output  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-013 Push SHALL occur on a rising edge when in_valid=1 and in_ready=1; word written at write pointer, write pointer increments.
REQ-014 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1; read pointer increments.
REQ-015 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend on out_ready (no pass-through when full).
REQ-016 out_valid SHALL equal (count != 0); it SHALL NOT depend on in_valid (no bypass when empty).
REQ-017 out_data SHALL be the entry at the read pointer, combinational from storage (first-word fall-through).
REQ-018 out_data SHALL be all zeros whenever count=0.
REQ-019 Latency: a word pushed at edge N SHALL be visible on out_data with out_valid=1 after edge N, if the queue was empty.
REQ-020 Order SHALL be strictly FIFO; no word duplicated or dropped.
REQ-021 Push and pop in the same cycle: both SHALL occur; count unchanged.
REQ-022 Push only: count +1; pop only: count -1; neither: all state held.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 in_valid while in_ready=0 SHALL be ignored; storage and count unchanged.
REQ-025 out_ready while out_valid=0 SHALL be ignored; read pointer unchanged.
REQ-026 flush=1 at an edge SHALL set count, read and write pointers to 0; any push or pop requested that cycle SHALL be discarded.
REQ-027 Storage contents need not be cleared by flush or reset; only pointers and count.
REQ-028 count, in_ready, out_valid SHALL be registered-state derived, glitch-free relative to inputs.

Reset
REQ-029 rst=0 at a rising edge SHALL clear count, read pointer and write pointer to 0, overriding flush, push and pop.
REQ-030 After reset: count=0, out_valid=0, in_ready=1, out_data=0.
REQ-031 rst asserted mid-operation (queue partially full) SHALL discard all entries on that edge; rst has no asynchronous effect between edges.

Verification
REQ-032 Reset: rst=0 for 2 edges with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_data=0; rst deasserting then no push -> count stays 0.
REQ-033 Fill: push 40'hAABBCCDDEE, 40'h1122334455, 40'h0000000001, 40'hFFFFFFFFFF with out_ready=0 -> count=4, in_ready=0; fifth push 40'h123456789A ignored; then drain with out_ready=1 -> out_data sequence AABBCCDDEE, 1122334455, 0000000001, FFFFFFFFFF, then out_valid=0, out_data=0.
REQ-034 Simultaneous: with count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap, output order matches input order.
REQ-035 Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next edge count=0, out_valid=0; pushed word not present afterward.
REQ-036 Empty/fall-through: empty queue, single push 40'hAABBCCDDEE at edge N -> out_valid=1, out_data=AABBCCDDEE after edge N; out_ready=1 on empty queue -> no count underflow.
REQ-037 Random: 1000 cycles random in_valid, out_ready, in_data (two concatenated 32-bit randoms), rare flush -> every popped word matches a scoreboard queue model; count matches model every cycle.
